adc_acq_seq: RTL

ADC_ACQ_SEQ -- requirements
Module: adc_acq_seq

---
 rtl/sig_acq_pkg.sv | 27 ++
 rtl/acq_fifo.sv | 58 +++++
 rtl/adc_acq_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sig_acq_pkg.sv
// Shared definitions for the ADC acquisition sequencer: FSM encoding,
// default timing constants, entry layout and a saturating increment helper.
package sig_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CONV = 3'd1,
    ST_WAIT = 3'd2,
    ST_READ = 3'd3,
    ST_PUSH = 3'd4
  } acq_state_e;

  localparam int DEF_CONV_CYCLES = 8;
  localparam int DEF_RD_CYCLES   = 4;
  localparam int DEF_BUSY_TMO    = 255;
  localparam int DEF_FIFO_DEPTH  = 4;

  localparam int TS_W     = 32;
  localparam int SAMPLE_W = 16;
  localparam int ENTRY_W  = TS_W + SAMPLE_W;
  localparam int CNT_W    = 16;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/acq_fifo.sv
// First-word-fall-through buffer for acquisition entries; a push and a pop
// in the same cycle both succeed even when the buffer is full.
module acq_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd_en = pop && valid;
  // When full, the slot being popped is the one that gets overwritten.
  assign wr_en = push && (!full || rd_en);
  assign dout  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_acq_seq.sv
// Triggered ADC acquisition: convst pulse, busy wait with timeout, parallel
// read, then timestamped entry into an output buffer with a per-second rate.
module adc_acq_seq
  import sig_acq_pkg::*;
#(
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int RD_CYCLES   = DEF_RD_CYCLES,
  parameter int BUSY_TMO    = DEF_BUSY_TMO,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        clr,
  input  logic        trig,
  input  logic [31:0] tstamp,
  input  logic        pulse_1s,
  output logic        adc_convst,
  input  logic        adc_busy,
  output logic        adc_cs_n,
  output logic        adc_rd_n,
  input  logic [15:0] adc_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_tstamp,
  output logic [15:0] out_sample,
  output logic        ovf,
  output logic        trig_miss,
  output logic        tmo,
  output logic [15:0] rate,
  output logic [2:0]  dbg_state
);

  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(BUSY_TMO - 1);

  acq_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              busy_s1, busy_s2;
  logic [TS_W-1:0]   ts_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic              capture, push, tmo_set;
  logic              fifo_full, fifo_pop, push_ok;
  logic [15:0]       rate_cnt;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
    end else begin
      busy_s1 <= adc_busy;
      busy_s2 <= busy_s1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    capture   = 1'b0;
    push      = 1'b0;
    tmo_set   = 1'b0;
    if (clr) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt = '0;
          if (trig && ena) state_nxt = ST_CONV;
        end
        ST_CONV: begin
          if (cnt == CONV_LAST) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = '0;
          end
        end
        ST_WAIT: begin
          // Busy is ignored for the first two WAIT cycles to cover the
          // synchroniser delay after convst falls.
          if (cnt >= CNT_W'(2) && !busy_s2) begin
            state_nxt = ST_READ;
            cnt_nxt   = '0;
          end else if (cnt == TMO_LAST) begin
            tmo_set   = 1'b1;
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
        ST_READ: begin
          if (cnt == RD_LAST) begin
            capture   = 1'b1;
            state_nxt = ST_PUSH;
            cnt_nxt   = '0;
          end
        end
        ST_PUSH: begin
          push      = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ADC strobes are registered from the next state so they track the FSM glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_convst <= 1'b0;
      adc_cs_n   <= 1'b1;
      adc_rd_n   <= 1'b1;
    end else begin
      adc_convst <= (state_nxt == ST_CONV);
      adc_cs_n   <= (state_nxt != ST_READ);
      adc_rd_n   <= (state_nxt != ST_READ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q     <= '0;
      sample_q <= '0;
    end else begin
      if (state == ST_IDLE && state_nxt == ST_CONV) ts_q <= tstamp;
      if (capture) sample_q <= adc_data;
    end
  end

  // Output handshake: an entry transfers on any cycle where out_valid and
  // out_ready are both high; out_valid never drops without a transfer or clr.
  assign fifo_pop = out_valid && out_ready;
  assign push_ok  = push && (!fifo_full || fifo_pop);

  acq_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .din   ({ts_q, sample_q}),
    .pop   (fifo_pop),
    .dout  ({out_tstamp, out_sample}),
    .valid (out_valid),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf       <= 1'b0;
      trig_miss <= 1'b0;
      tmo       <= 1'b0;
    end else if (clr) begin
      ovf       <= 1'b0;
      trig_miss <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      if (push && !push_ok) ovf <= 1'b1;
      if (trig && ena && state != ST_IDLE) trig_miss <= 1'b1;
      if (tmo_set) tmo <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate     <= '0;
      rate_cnt <= '0;
    end else if (clr) begin
      rate     <= '0;
      rate_cnt <= '0;
    end else if (pulse_1s) begin
      rate     <= push_ok ? sat_inc(rate_cnt) : rate_cnt;
      rate_cnt <= push_ok ? 16'd1 : 16'd0;
    end else if (push_ok) begin
      rate_cnt <= sat_inc(rate_cnt);
    end
  end

endmodule
